// File: rtl/sprite_line_ctrl.sv
// sprite_line_ctrl: fetches one sprite row per line during hblank, then loads and
// shifts a 16-pixel 2bpp shift register. Optional build macro: SPRITE_FLIP_EN.
module sprite_line_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  input  logic              sprite_on,
  input  logic [10:0]       sprite_x,
  input  logic [9:0]        sprite_y,
  input  logic [ADDR_W-1:0] base_addr,
`ifdef SPRITE_FLIP_EN
  input  logic              flip_h,
`endif
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_valid,
  input  logic [31:0]       rd_data,
  output logic              shift_ld,
  output logic              shift_en,
  output logic [31:0]       shift_data,
  output logic              line_miss
);

  localparam logic [10:0] H_FETCH = 11'(H_ACTIVE - 1);
  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ABORT = 11'(H_TOTAL - 2);
  localparam logic [9:0]  V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);

  typedef enum logic [2:0] {IDLE, WAIT, LOAD, ARMED, SHIFT} state_t;

  state_t              state_q;
  logic                rd_req_q, shift_ld_q, shift_en_q, line_miss_q;
  logic [ADDR_W-1:0]   rd_addr_q, base_q;
  logic [31:0]         shift_data_q;
  logic                on_q;
  logic [10:0]         x_q, xarm_q;
  logic [9:0]          y_q;
  logic                wrap_q;
  logic [3:0]          cnt_q;

  logic [9:0]          next_line_d, row_d;
  logic                hit_d, latch_d, fire_d;
  logic [31:0]         load_d;

`ifdef SPRITE_FLIP_EN
  logic                flip_q;

  function automatic logic [31:0] flip_fields(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 16; i++) r[2*i +: 2] = w[2*(15-i) +: 2];
    return r;
  endfunction

  assign load_d = flip_q ? flip_fields(rd_data) : rd_data;
`else
  assign load_d = rd_data;
`endif

  // Row arithmetic for the line that follows the current one.
  assign next_line_d = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
  assign row_d       = next_line_d - y_q;
  assign hit_d       = on_q && (next_line_d < V_ACT) && (next_line_d >= y_q) &&
                       (row_d[9:4] == 6'd0);
  assign latch_d     = (hcount == 11'd0) && (vcount == V_ACT);

  // Outputs are registered, so the enable decision is taken two columns before
  // the pixel; x==1 therefore fires on the last column of the fetch line.
  assign fire_d = (xarm_q == 11'd1) ? (hcount == H_LAST)
                                    : (wrap_q && (hcount == xarm_q - 11'd2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rd_req_q     <= 1'b0;
      rd_addr_q    <= '0;
      shift_ld_q   <= 1'b0;
      shift_en_q   <= 1'b0;
      shift_data_q <= '0;
      line_miss_q  <= 1'b0;
      on_q         <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      base_q       <= '0;
      xarm_q       <= '0;
      wrap_q       <= 1'b0;
      cnt_q        <= '0;
`ifdef SPRITE_FLIP_EN
      flip_q       <= 1'b0;
`endif
    end else begin
      rd_req_q   <= 1'b0;
      shift_ld_q <= 1'b0;
      if (latch_d) begin
        on_q        <= sprite_on;
        x_q         <= (sprite_x == 11'd0) ? 11'd1 : sprite_x;
        y_q         <= sprite_y;
        base_q      <= base_addr;
        line_miss_q <= 1'b0;
`ifdef SPRITE_FLIP_EN
        flip_q      <= flip_h;
`endif
      end
      case (state_q)
        IDLE: begin
          if (hcount == H_FETCH && hit_d) begin
            rd_req_q  <= 1'b1;
            rd_addr_q <= base_q + ADDR_W'(row_d[3:0]);
            xarm_q    <= x_q;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (rd_valid) begin
            shift_data_q <= load_d;
            shift_ld_q   <= 1'b1;
            state_q      <= LOAD;
          end else if (hcount == H_LAST) begin
            line_miss_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        LOAD: begin
          wrap_q  <= 1'b0;
          state_q <= ARMED;
        end
        ARMED: begin
          if (hcount == H_LAST) wrap_q <= 1'b1;
          if (fire_d) begin
            shift_en_q <= 1'b1;
            cnt_q      <= 4'd0;
            state_q    <= SHIFT;
          end else if (wrap_q && hcount == H_ABORT) begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          if (cnt_q == 4'd15) begin
            shift_en_q <= 1'b0;
            state_q    <= IDLE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_req     = rd_req_q;
  assign rd_addr    = rd_addr_q;
  assign shift_ld   = shift_ld_q;
  assign shift_en   = shift_en_q;
  assign shift_data = shift_data_q;
  assign line_miss  = line_miss_q;

endmodule

// File: tb/tb_sprite_line_ctrl.sv
// tb_sprite_line_ctrl: directed bench with a line-level model of fetch, load and
// shift timing plus a downstream shift register. Builds with or without SPRITE_FLIP_EN.
`timescale 1ns/1ps
module tb_sprite_line_ctrl;
  localparam int HA = 640, HT = 800, VA = 480, VT = 525;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        sprite_on;
  logic [10:0] sprite_x;
  logic [9:0]  sprite_y;
  logic [7:0]  base_addr;
`ifdef SPRITE_FLIP_EN
  logic        flip_h;
`endif
  logic        rd_req;
  logic [7:0]  rd_addr;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        shift_ld, shift_en;
  logic [31:0] shift_data;
  logic        line_miss;

  sprite_line_ctrl dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .sprite_on(sprite_on), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .base_addr(base_addr),
`ifdef SPRITE_FLIP_EN
    .flip_h(flip_h),
`endif
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .shift_ld(shift_ld), .shift_en(shift_en), .shift_data(shift_data),
    .line_miss(line_miss)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int cur_h = 0, cur_v = 0;
  int norm_lat = 3, miss_line = -1;
  int pend = 0;
  logic [7:0] pend_addr = '0;
  logic [31:0] mem [256];
  bit run_on = 0, jmp_req = 0, jmp_flag = 1, rst_flag = 1;
  int jmp_h = 0, jmp_v = 0;

  // Downstream shift register: the pixel register updates only on enable.
  logic [31:0] sr;
  logic [1:0]  pix;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sr  <= '0;
      pix <= '0;
    end else if (shift_ld) begin
      sr <= shift_data;
    end else if (shift_en) begin
      pix <= sr[31:30];
      sr  <= {sr[29:0], 2'b00};
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at v=%0d h=%0d: got 0x%0h expected 0x%0h", nm, cur_v, cur_h, act, exp);
    end
  endtask

  function automatic int lat_for(input int v);
    return (v == miss_line) ? 200 : norm_lat;
  endfunction

  function automatic logic [31:0] rev_fields(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 16; i++) r[2*i +: 2] = w[2*(15-i) +: 2];
    return r;
  endfunction

  // One pixel clock: advance position, then play the sprite memory.
  task automatic step();
    @(posedge clk); #1;
    if (jmp_req) begin
      cur_h = jmp_h; cur_v = jmp_v; jmp_req = 0; jmp_flag = 1;
    end else begin
      cur_h++;
      if (cur_h == HT) begin
        cur_h = 0;
        cur_v = (cur_v == VT-1) ? 0 : cur_v + 1;
      end
    end
    hcount   = 11'(cur_h);
    vcount   = 10'(cur_v);
    rd_valid = 1'b0;
    rd_data  = 32'hDEAD_BEEF;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        rd_valid = 1'b1;
        rd_data  = mem[pend_addr];
      end
    end
    if (rd_req) begin
      pend      = lat_for(cur_v);
      pend_addr = rd_addr;
    end
  endtask

  task automatic goto_pos(input int v, input int h);
    int n;
    n = 0;
    while (!(cur_v == v && cur_h == h) && n < 20000) begin
      step();
      n++;
    end
    if (!(cur_v == v && cur_h == h)) begin
      n_err++;
      $display("FAIL goto timeout: at v=%0d h=%0d wanted v=%0d h=%0d", cur_v, cur_h, v, h);
    end
  endtask

  task automatic jump(input int v, input int h);
    jmp_v = v; jmp_h = h; jmp_req = 1;
    step();
  endtask

  task automatic set_sprite(input int x, input int y, input int base);
    sprite_on = 1'b1;
    sprite_x  = 11'(x);
    sprite_y  = 10'(y);
    base_addr = 8'(base);
  endtask

  task automatic frame_latch();
    jump(VA, 0);
    goto_pos(VA, 600);
  endtask

  // Behavioural model: per-line fetch plan derived from frame-latched values.
  int m_x = 0, m_y = 0, m_base = 0, m_on = 0, m_flip = 0, m_miss = 0;
  int p_h = 0, p_v = 0, en_line = -1, en_x = 0;
  int f_hit = 0, f_ok = 0, f_lat = 0, f_addr = 0;
  logic [31:0] exp_sd = '0;

  always @(negedge clk) begin
    if (run_on) begin
      int fresh, nl, row;
      bit exp_req, exp_ld, exp_en;
      fresh = 0;
      if (rst_flag) begin
        rst_flag = 0; fresh = 1;
        m_x = 0; m_y = 0; m_base = 0; m_on = 0; m_flip = 0; m_miss = 0;
        exp_sd = '0;
      end
      if (jmp_flag) begin
        jmp_flag = 0; fresh = 1;
      end
      if (fresh != 0) begin
        en_line = -1; f_hit = 0;
      end else begin
        if (p_h == 0 && p_v == VA) begin
          m_on = int'(sprite_on);
          m_x  = (sprite_x == 11'd0) ? 1 : int'(sprite_x);
          m_y  = int'(sprite_y);
          m_base = int'(base_addr);
`ifdef SPRITE_FLIP_EN
          m_flip = int'(flip_h);
`endif
          m_miss = 0;
        end
        if (p_h == HT-1 && f_hit != 0 && f_ok == 0) m_miss = 1;
      end
      if (cur_h == 0 && cur_v != en_line) en_line = -1;
      if (cur_h == HA) begin
        nl    = (cur_v == VT-1) ? 0 : cur_v + 1;
        row   = nl - m_y;
        f_hit = (m_on != 0 && nl < VA && row >= 0 && row <= 15) ? 1 : 0;
        f_lat = lat_for(cur_v);
        f_ok  = (HA + f_lat <= HT-1) ? 1 : 0;
        f_addr = (m_base + row) & 255;
        if (f_hit != 0 && f_ok != 0) begin
          en_line = nl; en_x = m_x;
        end
      end
      exp_req = (cur_h == HA) && f_hit != 0;
      exp_ld  = f_hit != 0 && f_ok != 0 && cur_h == HA + 1 + f_lat;
      if (exp_ld) exp_sd = (m_flip != 0) ? rev_fields(mem[f_addr]) : mem[f_addr];
      exp_en  = (cur_v == en_line) && (cur_h >= en_x - 1) && (cur_h <= en_x + 14);
      chk("rd_req", 32'(rd_req), 32'(exp_req));
      if (exp_req) chk("rd_addr", 32'(rd_addr), 32'(f_addr));
      chk("shift_ld", 32'(shift_ld), 32'(exp_ld));
      chk("shift_en", 32'(shift_en), 32'(exp_en));
      chk("shift_data", shift_data, exp_sd);
      chk("line_miss", 32'(line_miss), 32'(m_miss));
      p_h = cur_h; p_v = cur_v;
    end
  end

  initial begin
    for (int i = 0; i < 256; i++)
      mem[i] = {8'(i), 8'(i) ^ 8'hC3, 16'h0F0F + 16'(i)};
    mem[8'h20] = 32'hE400_0000;
    mem[8'h40] = 32'hC000_0000;
    reset = 1'b1; hcount = '0; vcount = '0; sprite_on = 1'b0; sprite_x = '0;
    sprite_y = '0; base_addr = '0; rd_valid = 1'b0; rd_data = '0;
`ifdef SPRITE_FLIP_EN
    flip_h = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst rd_req", 32'(rd_req), 32'd0);
    chk("rst rd_addr", 32'(rd_addr), 32'd0);
    chk("rst shift_ld", 32'(shift_ld), 32'd0);
    chk("rst shift_en", 32'(shift_en), 32'd0);
    chk("rst shift_data", shift_data, 32'd0);
    chk("rst line_miss", 32'(line_miss), 32'd0);
    reset = 1'b0;
    run_on = 1;

    // Basic fetch, load and shift with read latency 3.
    set_sprite(100, 50, 8'h20);
    frame_latch();
    jump(48, 600);
    goto_pos(49, 640);
    chk("s1 rd_req", 32'(rd_req), 32'd1);
    chk("s1 rd_addr", 32'(rd_addr), 32'h20);
    goto_pos(49, 644);
    chk("s1 shift_ld", 32'(shift_ld), 32'd1);
    chk("s1 shift_data", shift_data, 32'hE400_0000);
    goto_pos(50, 98);  chk("s1 en 98", 32'(shift_en), 32'd0);
    goto_pos(50, 99);  chk("s1 en 99", 32'(shift_en), 32'd1);
    goto_pos(50, 100); chk("s1 pix 100", 32'(pix), 32'd3);
    goto_pos(50, 101); chk("s1 pix 101", 32'(pix), 32'd2);
    goto_pos(50, 102); chk("s1 pix 102", 32'(pix), 32'd1);
    goto_pos(50, 103); chk("s1 pix 103", 32'(pix), 32'd0);
    goto_pos(50, 114); chk("s1 en 114", 32'(shift_en), 32'd1);
    goto_pos(50, 115); chk("s1 en 115", 32'(shift_en), 32'd0);
    goto_pos(51, 600);

    // Bottom clipping plus one withheld read on line 473.
    set_sprite(100, 470, 8'h20);
    miss_line = 473;
    frame_latch();
    jump(468, 600);
    goto_pos(469, 640);
    chk("s2 rd_req 469", 32'(rd_req), 32'd1);
    chk("s2 rd_addr 469", 32'(rd_addr), 32'h20);
    goto_pos(474, 0);  chk("s2 miss set", 32'(line_miss), 32'd1);
    goto_pos(474, 99); chk("s2 no en 474", 32'(shift_en), 32'd0);
    goto_pos(475, 99); chk("s2 en 475", 32'(shift_en), 32'd1);
    goto_pos(478, 640);
    chk("s2 rd_req 478", 32'(rd_req), 32'd1);
    chk("s2 rd_addr 478", 32'(rd_addr), 32'h29);
    goto_pos(479, 5);   chk("s2 miss sticky", 32'(line_miss), 32'd1);
    goto_pos(479, 640); chk("s2 rd_req 479", 32'(rd_req), 32'd0);
    goto_pos(480, 1);   chk("s2 miss clear", 32'(line_miss), 32'd0);
    goto_pos(480, 640); chk("s2 rd_req 480", 32'(rd_req), 32'd0);
    goto_pos(481, 600);
    miss_line = -1;

    // sprite_x changes mid-frame; takes effect only after the frame latch.
    set_sprite(100, 195, 8'h20);
    frame_latch();
    jump(194, 600);
    goto_pos(200, 0);
    sprite_x = 11'd300;
    goto_pos(201, 99);  chk("s4 old x en", 32'(shift_en), 32'd1);
    goto_pos(201, 299); chk("s4 old x no en", 32'(shift_en), 32'd0);
    goto_pos(201, 600);
    frame_latch();
    jump(196, 600);
    goto_pos(197, 99);  chk("s4 new x no en", 32'(shift_en), 32'd0);
    goto_pos(197, 299); chk("s4 new x en 299", 32'(shift_en), 32'd1);
    goto_pos(197, 314); chk("s4 new x en 314", 32'(shift_en), 32'd1);
    goto_pos(197, 315); chk("s4 new x en 315", 32'(shift_en), 32'd0);
    goto_pos(197, 600);

    // sprite_x == 0 behaves as 1: enables on columns 0..15.
    set_sprite(0, 100, 8'h40);
    frame_latch();
    jump(99, 600);
    goto_pos(99, 799);  chk("s5 en 799", 32'(shift_en), 32'd0);
    goto_pos(100, 0);   chk("s5 en 0", 32'(shift_en), 32'd1);
    goto_pos(100, 1);   chk("s5 pix 1", 32'(pix), 32'd3);
    goto_pos(100, 2);   chk("s5 pix 2", 32'(pix), 32'd0);
    goto_pos(100, 15);  chk("s5 en 15", 32'(shift_en), 32'd1);
    goto_pos(100, 16);  chk("s5 en 16", 32'(shift_en), 32'd0);
    goto_pos(100, 600);

    // Asynchronous reset in the middle of the shift burst.
    set_sprite(100, 50, 8'h20);
    frame_latch();
    jump(49, 600);
    goto_pos(50, 106);
    chk("s6 en before rst", 32'(shift_en), 32'd1);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    chk("s6 rst shift_en", 32'(shift_en), 32'd0);
    chk("s6 rst shift_ld", 32'(shift_ld), 32'd0);
    chk("s6 rst rd_req", 32'(rd_req), 32'd0);
    chk("s6 rst shift_data", shift_data, 32'd0);
    chk("s6 rst line_miss", 32'(line_miss), 32'd0);
    rst_flag = 1;
    pend = 0;
    step();
    reset = 1'b0;
    goto_pos(50, 600);
    frame_latch();
    jump(49, 600);
    goto_pos(50, 99);  chk("s6 en after rst", 32'(shift_en), 32'd1);
    goto_pos(50, 100); chk("s6 pix after rst", 32'(pix), 32'd3);
    goto_pos(50, 600);

`ifdef SPRITE_FLIP_EN
    // Horizontal flip reverses the 2-bit fields of the fetched row.
    flip_h = 1'b1;
    frame_latch();
    jump(49, 600);
    goto_pos(49, 644);
    chk("s7 flip data", shift_data, 32'h0000_001B);
    goto_pos(50, 600);
`endif

    run_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
